// File: rtl/fir_tdm_multichannel.sv
// Time-multiplexed multichannel FIR: one shared signed MAC, banked run-time coefficients,
// round-half-up and saturation, ready/valid on both sides.
module fir_tdm_multichannel #(
    parameter int N_CH    = 3,
    parameter int N_TAPS  = 16,
    parameter int N_BANKS = 4,
    parameter int DW      = 16,
    parameter int CW      = 16,
    parameter int FRAC    = 15,
    localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TAP_W  = $clog2(N_TAPS),
    localparam int ACC_W  = DW + CW + $clog2(N_TAPS)
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*DW-1:0]       in_data,
    input  logic [N_CH*BANK_W-1:0]   bank_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH*DW-1:0]       out_data,
    output logic                     out_irq,
    input  logic                     upd_en,
    input  logic [CH_W-1:0]          upd_ch,
    input  logic [BANK_W-1:0]        upd_bank,
    input  logic [TAP_W-1:0]         upd_idx,
    input  logic [CW-1:0]            upd_value
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int PW = DW + CW;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SMIN = -(ACC_W'(1) <<< (DW - 1));

    logic [1:0]               state;
    logic signed [DW-1:0]     dline [N_CH][N_TAPS];
    logic signed [CW-1:0]     coef  [N_CH][N_BANKS][N_TAPS];
    logic [BANK_W-1:0]        bank_q [N_CH];
    logic signed [ACC_W-1:0]  acc [N_CH];
    logic signed [ACC_W-1:0]  rnd [N_CH];
    logic signed [DW-1:0]     sat [N_CH];
    logic signed [PW-1:0]     mul_a;
    logic signed [PW-1:0]     mul_b;
    logic signed [PW-1:0]     prod;
    logic [CH_W-1:0]          ch_cnt;
    logic [CH_W-1:0]          prod_ch;
    logic [TAP_W-1:0]         tap_cnt;
    logic                     prod_vld;
    logic                     tap_last;
    logic                     mac_last;
    logic                     upd_ok;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign tap_last  = (tap_cnt == TAP_W'(N_TAPS - 1));
    assign mac_last  = tap_last && (ch_cnt == CH_W'(N_CH - 1));
    assign mul_a     = PW'(dline[ch_cnt][tap_cnt]);
    assign mul_b     = PW'(coef[ch_cnt][bank_q[ch_cnt]][tap_cnt]);
    assign upd_ok    = upd_en
                     && ({1'b0, upd_ch} < (CH_W + 1)'(N_CH))
                     && ({1'b0, upd_idx} < (TAP_W + 1)'(N_TAPS));

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            rnd[c] = (acc[c] + HALF) >>> FRAC;
            sat[c] = rnd[c][DW-1:0];
            if (rnd[c] > SMAX)
                sat[c] = SMAX[DW-1:0];
            else if (rnd[c] < SMIN)
                sat[c] = SMIN[DW-1:0];
        end
    end

    // Product is registered, so ROUND waits one cycle for the last product to land.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_irq  <= 1'b0;
            out_data <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            prod_ch  <= '0;
            ch_cnt   <= '0;
            tap_cnt  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c]    <= '0;
                bank_q[c] <= '0;
                for (int t = 0; t < N_TAPS; t++) begin
                    dline[c][t] <= '0;
                    for (int b = 0; b < N_BANKS; b++)
                        coef[c][b][t] <= '0;
                end
            end
        end else begin
            out_irq <= 1'b0;
            if (upd_ok)
                coef[upd_ch][upd_bank][upd_idx] <= upd_value;
            if (prod_vld)
                acc[prod_ch] <= acc[prod_ch] + ACC_W'(prod);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < N_CH; c++) begin
                            dline[c][0] <= in_data[c*DW +: DW];
                            for (int t = 1; t < N_TAPS; t++)
                                dline[c][t] <= dline[c][t-1];
                            bank_q[c] <= bank_sel[c*BANK_W +: BANK_W];
                            acc[c]    <= '0;
                        end
                        ch_cnt  <= '0;
                        tap_cnt <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    prod     <= mul_a * mul_b;
                    prod_ch  <= ch_cnt;
                    prod_vld <= 1'b1;
                    if (tap_last) begin
                        tap_cnt <= '0;
                        ch_cnt  <= ch_cnt + CH_W'(1);
                    end else begin
                        tap_cnt <= tap_cnt + TAP_W'(1);
                    end
                    if (mac_last)
                        state <= ROUND;
                end
                ROUND: begin
                    if (prod_vld) begin
                        prod_vld <= 1'b0;
                    end else begin
                        for (int c = 0; c < N_CH; c++)
                            out_data[c*DW +: DW] <= sat[c];
                        out_irq <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
